// File: rtl/clock_mode_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clock_mode_ctrl_if                                            |
// | Purpose  : Bundles the user-control inputs and the mode/increment/       |
// |            display outputs of clock_mode_ctrl.                           |
// | Signals  : i_tick_1hz, i_max_hit_sec, i_max_hit_min - timebase/carries   |
// |            i_sw_mode, i_sw_pos, i_sw_inc - raw active-low pushbuttons    |
// |            o_mode, o_position - current mode and selected field          |
// |            o_time_inc, o_alarm_inc - one-cycle increment enables         |
// |            o_blink_mask - per-digit blank request                        |
// |            o_alarm_en - alarm armed flag                                 |
// | Modports : master drives the inputs, slave (the controller) drives the   |
// |            outputs.                                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface clock_mode_ctrl_if;
   logic       i_tick_1hz;
   logic       i_sw_mode;
   logic       i_sw_pos;
   logic       i_sw_inc;
   logic       i_max_hit_sec;
   logic       i_max_hit_min;
   logic [1:0] o_mode;
   logic [1:0] o_position;
   logic [2:0] o_time_inc;
   logic [2:0] o_alarm_inc;
   logic [5:0] o_blink_mask;
   logic       o_alarm_en;

   modport master (
      output i_tick_1hz, i_sw_mode, i_sw_pos, i_sw_inc, i_max_hit_sec, i_max_hit_min,
      input  o_mode, o_position, o_time_inc, o_alarm_inc, o_blink_mask, o_alarm_en
   );

   modport slave (
      input  i_tick_1hz, i_sw_mode, i_sw_pos, i_sw_inc, i_max_hit_sec, i_max_hit_min,
      output o_mode, o_position, o_time_inc, o_alarm_inc, o_blink_mask, o_alarm_en
   );
endinterface
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clock_mode_ctrl                                               |
// | Purpose  : User-interface controller of a digital clock. Debounces the   |
// |            mode/pos/inc pushbuttons, runs the CLOCK/SETUP/ALARM mode     |
// |            machine, routes increment enables to the time or alarm        |
// |            registers and generates the digit blink mask.                 |
// | Ports    : clk   - system clock (only clock)                             |
// |            rst_n - asynchronous active-low reset                         |
// |            bus   - clock_mode_ctrl_if.slave (inputs i_*, outputs o_*)    |
// | Params   : DEB_CNT   - clk cycles a new switch level must hold           |
// |            BLINK_DIV - clk cycles per blink phase                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clock_mode_ctrl #(
   parameter int DEB_CNT   = 500000,
   parameter int BLINK_DIV = 25000000
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   clock_mode_ctrl_if.slave  bus
);

   localparam int              DEB_W      = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CNT - 1);
   localparam int              BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   localparam logic [1:0] POS_SEC  = 2'd0;
   localparam logic [1:0] POS_MIN  = 2'd1;
   localparam logic [1:0] POS_HOUR = 2'd2;

   typedef enum logic [1:0] {
      ST_CLOCK = 2'd0,
      ST_SETUP = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   // Switch order in the vectors below: 0 = mode, 1 = pos, 2 = inc
   logic [2:0] sw_raw;
   logic [2:0] press;

   assign sw_raw = {bus.i_sw_inc, bus.i_sw_pos, bus.i_sw_mode};

   // ------------------------------------------------------------------
   // Synchronizer + debounce + press detect, one per switch.
   // The synchronizer flops reset to the "pressed" level so that no real
   // release has been observed yet; a switch only becomes armed after a
   // genuine released sample, which keeps a button held through reset
   // from producing an event until it is released and pressed again.
   // ------------------------------------------------------------------
   generate
      for (genvar g = 0; g < 3; g++) begin : g_sw
         logic             sync1;
         logic             sync2;
         logic             level;
         logic             armed;
         logic             ev;
         logic [DEB_W-1:0] cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1 <= 1'b0;
               sync2 <= 1'b0;
               level <= 1'b1;
               armed <= 1'b0;
               ev    <= 1'b0;
               cnt   <= '0;
            end else begin
               sync1 <= sw_raw[g];
               sync2 <= sync1;
               ev    <= 1'b0;
               armed <= armed | (sync2 & level);
               if (sync2 == level) begin
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  level <= sync2;
                  cnt   <= '0;
                  ev    <= armed & ~sync2;   // falling edge of debounced level only
               end else begin
                  cnt <= cnt + DEB_W'(1);
               end
            end
         end

         assign press[g] = ev;
      end
   endgenerate

   // Event priority: mode beats pos and inc, pos beats inc.
   logic mode_ev;
   logic pos_ev;
   logic inc_ev;

   assign mode_ev = press[0];
   assign pos_ev  = press[1] & ~press[0];
   assign inc_ev  = press[2] & ~press[1] & ~press[0];

   // ------------------------------------------------------------------
   // Mode machine and output routing
   // ------------------------------------------------------------------
   state_t       state;
   state_t       state_nxt;
   logic [1:0]   pos;
   logic [1:0]   pos_nxt;
   logic [1:0]   pos_adv;
   logic [2:0]   pos_onehot;
   logic [2:0]   time_inc;
   logic [2:0]   time_inc_nxt;
   logic [2:0]   alarm_inc;
   logic [2:0]   alarm_inc_nxt;
   logic         alarm_en;
   logic         alarm_en_nxt;
   logic [2:0]   carries;

   assign carries    = {bus.i_max_hit_min, bus.i_max_hit_sec, bus.i_tick_1hz};
   assign pos_adv    = (pos >= POS_HOUR) ? POS_SEC : pos + 2'd1;
   assign pos_onehot = 3'b001 << pos;

   always_comb begin
      state_nxt     = state;
      pos_nxt       = pos;
      time_inc_nxt  = 3'b000;
      alarm_inc_nxt = 3'b000;
      alarm_en_nxt  = alarm_en;

      case (state)
         ST_CLOCK: begin
            time_inc_nxt = carries;
            if (mode_ev) begin
               state_nxt = ST_SETUP;
            end
            if (inc_ev) begin
               alarm_en_nxt = ~alarm_en;
            end
         end
         ST_SETUP: begin
            // Running time is frozen while it is being edited.
            if (mode_ev) begin
               state_nxt = ST_ALARM;
            end else if (pos_ev) begin
               pos_nxt = pos_adv;
            end
            if (inc_ev) begin
               time_inc_nxt = pos_onehot;
            end
         end
         ST_ALARM: begin
            time_inc_nxt = carries;
            if (mode_ev) begin
               state_nxt = ST_CLOCK;
            end else if (pos_ev) begin
               pos_nxt = pos_adv;
            end
            if (inc_ev) begin
               alarm_inc_nxt = pos_onehot;
            end
         end
         default: begin
            state_nxt = ST_CLOCK;          // unused encoding recovers
         end
      endcase

      if (state_nxt != state) begin
         pos_nxt = POS_SEC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_CLOCK;
         pos       <= POS_SEC;
         time_inc  <= 3'b000;
         alarm_inc <= 3'b000;
         alarm_en  <= 1'b0;
      end else begin
         state     <= state_nxt;
         pos       <= pos_nxt;
         time_inc  <= time_inc_nxt;
         alarm_inc <= alarm_inc_nxt;
         alarm_en  <= alarm_en_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Blink timebase; restarts at phase 0 whenever the user moves so the
   // newly selected field is shown solid first.
   // ------------------------------------------------------------------
   logic               blink_restart;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic [5:0]         blink_mask;

   assign blink_restart = (state_nxt != state) || (pos_nxt != pos);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_restart) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
   end

   always_comb begin
      blink_mask = 6'b000000;
      if (blink_phase && (state == ST_SETUP || state == ST_ALARM)) begin
         case (pos)
            POS_SEC:  blink_mask = 6'b000011;
            POS_MIN:  blink_mask = 6'b001100;
            POS_HOUR: blink_mask = 6'b110000;
            default:  blink_mask = 6'b000000;
         endcase
      end
   end

   assign bus.o_mode       = state;
   assign bus.o_position   = pos;
   assign bus.o_time_inc   = time_inc;
   assign bus.o_alarm_inc  = alarm_inc;
   assign bus.o_alarm_en   = alarm_en;
   assign bus.o_blink_mask = blink_mask;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clock_mode_ctrl                                            |
// | Purpose  : Self-checking bench for clock_mode_ctrl (DEB_CNT=4,           |
// |            BLINK_DIV=8). A behavioural reference model tracks the        |
// |            expected outputs every cycle; directed steps add fixed checks |
// |            and a randomized phase exercises overlapping button activity. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_clock_mode_ctrl;

   localparam int DEB   = 4;
   localparam int BLINK = 8;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [2:0] sw      = 3'b111;   // {inc, pos, mode}, active-low
   logic       tick    = 1'b0;
   logic       hit_sec = 1'b0;
   logic       hit_min = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   clock_mode_ctrl_if bus ();

   assign bus.i_sw_mode     = sw[0];
   assign bus.i_sw_pos      = sw[1];
   assign bus.i_sw_inc      = sw[2];
   assign bus.i_tick_1hz    = tick;
   assign bus.i_max_hit_sec = hit_sec;
   assign bus.i_max_hit_min = hit_min;

   clock_mode_ctrl #(
      .DEB_CNT   (DEB),
      .BLINK_DIV (BLINK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   // Each button: raw level reaches the debouncer two edges later; the
   // debounced level follows once the last DEB samples all disagree with it.
   bit   d1 [3];
   bit   d2 [3];
   bit   lvl [3];
   bit   armed [3];
   bit   ev [3];
   bit   win [3][DEB];
   int   m_mode;
   int   m_pos;
   int   m_bc;
   bit   m_phase;
   bit   m_alen;
   logic [2:0] m_time;
   logic [2:0] m_alarm;

   function automatic void model_reset();
      for (int s = 0; s < 3; s++) begin
         d1[s] = 1'b0;     // nothing real seen yet: treated as not released
         d2[s] = 1'b0;
         lvl[s] = 1'b1;
         armed[s] = 1'b0;
         ev[s] = 1'b0;
         for (int k = 0; k < DEB; k++) win[s][k] = 1'b1;
      end
      m_mode  = 0;
      m_pos   = 0;
      m_bc    = 0;
      m_phase = 1'b0;
      m_alen  = 1'b0;
      m_time  = 3'b000;
      m_alarm = 3'b000;
   endfunction

   function automatic void model_step();
      bit pm, pp, pi, changed, all_diff, smp, old_lvl;
      int old_mode, old_pos;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pm = ev[0];
      pp = ev[1] && !pm;
      pi = ev[2] && !pm && !pp;
      old_mode = m_mode;
      old_pos  = m_pos;

      m_time  = (old_mode == 1) ? (pi ? 3'(1 << old_pos) : 3'b000)
                                : {hit_min, hit_sec, tick};
      m_alarm = (old_mode == 2 && pi) ? 3'(1 << old_pos) : 3'b000;
      if (old_mode == 0 && pi) m_alen = !m_alen;

      changed = 1'b0;
      if (pm) begin
         m_mode  = (m_mode + 1) % 3;
         m_pos   = 0;
         changed = 1'b1;
      end else if (pp && old_mode != 0) begin
         m_pos   = (m_pos + 1) % 3;
         changed = 1'b1;
      end

      if (changed) begin
         m_bc    = 0;
         m_phase = 1'b0;
      end else begin
         m_bc = m_bc + 1;
         if (m_bc == BLINK) begin
            m_bc    = 0;
            m_phase = !m_phase;
         end
      end

      for (int s = 0; s < 3; s++) begin
         smp   = d2[s];
         d2[s] = d1[s];
         d1[s] = sw[s];
         for (int k = 0; k < DEB - 1; k++) win[s][k] = win[s][k+1];
         win[s][DEB-1] = smp;
         all_diff = 1'b1;
         for (int k = 0; k < DEB; k++) if (win[s][k] == lvl[s]) all_diff = 1'b0;
         old_lvl = lvl[s];
         ev[s]   = 1'b0;
         if (all_diff) begin
            lvl[s] = smp;
            ev[s]  = !smp && armed[s];
         end
         armed[s] = armed[s] | (smp && old_lvl);
      end
   endfunction

   function automatic int exp_mask();
      if (m_mode == 0 || !m_phase) return 0;
      return 3 << (2 * m_pos);
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int obs, input int expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("mode",       int'(bus.o_mode),       m_mode);
      chk("position",   int'(bus.o_position),   m_pos);
      chk("time_inc",   int'(bus.o_time_inc),   int'(m_time));
      chk("alarm_inc",  int'(bus.o_alarm_inc),  int'(m_alarm));
      chk("blink_mask", int'(bus.o_blink_mask), exp_mask());
      chk("alarm_en",   int'(bus.o_alarm_en),   int'(m_alen));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input int s, input int hold);
      sw[s] = 1'b0;
      repeat (hold) cycle();
      sw[s] = 1'b1;
      repeat (DEB + 4) cycle();
   endtask

   int cnt;
   int hold_left [3];

   initial begin
      model_reset();

      // Reset state
      repeat (3) cycle();
      chk("rst_mode",  int'(bus.o_mode), 0);
      chk("rst_mask",  int'(bus.o_blink_mask), 0);
      chk("rst_alen",  int'(bus.o_alarm_en), 0);
      rst_n = 1'b1;
      repeat (6) cycle();

      // CLOCK: tick and carry pass through with one cycle of latency
      tick = 1'b1;
      cycle();
      chk("tick_n1", int'(bus.o_time_inc), 'b001);
      tick = 1'b0;
      cycle();
      chk("tick_single", int'(bus.o_time_inc), 'b000);
      repeat (3) cycle();
      hit_sec = 1'b1;
      cycle();
      chk("sec_m1", int'(bus.o_time_inc), 'b010);
      hit_sec = 1'b0;
      cycle();
      chk("sec_single", int'(bus.o_time_inc), 'b000);
      hit_min = 1'b1;
      cycle();
      chk("min_m1", int'(bus.o_time_inc), 'b100);
      hit_min = 1'b0;
      cycle();

      // CLOCK: inc toggles alarm enable
      press(2, 6);
      chk("alen_on", int'(bus.o_alarm_en), 1);

      // Short glitch on mode is rejected, a 6-cycle press is accepted once
      press(0, 3);
      chk("glitch_mode", int'(bus.o_mode), 0);
      press(0, 6);
      chk("mode_setup", int'(bus.o_mode), 1);
      chk("mode_setup_pos", int'(bus.o_position), 0);

      // SETUP: pos twice -> HOUR, inc -> single hour increment, ticks ignored
      press(1, 6);
      press(1, 6);
      chk("setup_pos_hour", int'(bus.o_position), 2);
      cnt = 0;
      sw[2] = 1'b0;
      repeat (6) cycle();
      sw[2] = 1'b1;
      repeat (DEB + 4) begin
         cycle();
         if (bus.o_time_inc == 3'b100) cnt++;
      end
      chk("setup_inc_pulses", cnt, 1);
      cnt = 0;
      repeat (5) begin
         tick = 1'b1;
         cycle();
         tick = 1'b0;
         cycle();
         if (bus.o_time_inc != 3'b000) cnt++;
      end
      chk("setup_tick_ignored", cnt, 0);

      // ALARM: select MIN, then watch one full blink period
      press(0, 6);
      chk("mode_alarm", int'(bus.o_mode), 2);
      sw[1] = 1'b0;
      repeat (6) cycle();
      sw[1] = 1'b1;
      for (int k = 0; k < 17; k++) begin
         cycle();
         if (k == 0) chk("alarm_pos_min", int'(bus.o_position), 1);
         chk("blink_seq", int'(bus.o_blink_mask),
             (k >= 8 && k < 16) ? 'b001100 : 'b000000);
      end
      press(2, 6);
      press(1, 6);
      chk("alarm_pos_hour", int'(bus.o_position), 2);

      // Mode and inc together in SETUP: mode wins, no increments
      press(0, 6);
      press(0, 6);
      chk("back_setup", int'(bus.o_mode), 1);
      cnt = 0;
      sw[0] = 1'b0;
      sw[2] = 1'b0;
      repeat (6) cycle();
      sw[0] = 1'b1;
      sw[2] = 1'b1;
      repeat (DEB + 6) begin
         cycle();
         if (bus.o_time_inc != 3'b000 || bus.o_alarm_inc != 3'b000) cnt++;
      end
      chk("mode_beats_inc_mode", int'(bus.o_mode), 2);
      chk("mode_beats_inc_none", cnt, 0);

      // Reset mid-SETUP with inc held
      press(0, 6);
      press(0, 6);
      sw[2] = 1'b0;
      repeat (3) cycle();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_rst_mode", int'(bus.o_mode), 0);
      repeat (2) cycle();
      rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         cycle();
         if (bus.o_time_inc != 3'b000 || bus.o_alarm_en) cnt++;
      end
      chk("held_no_event", cnt, 0);
      sw[2] = 1'b1;
      repeat (8) cycle();
      press(2, 6);
      chk("rearm_alen", int'(bus.o_alarm_en), 1);

      // Randomized overlapping button activity and carries
      for (int s = 0; s < 3; s++) hold_left[s] = 0;
      repeat (1500) begin
         for (int s = 0; s < 3; s++) begin
            if (hold_left[s] == 0) begin
               sw[s] = 1'($urandom_range(0, 1));
               hold_left[s] = int'($urandom_range(1, 10));
            end
            hold_left[s]--;
         end
         tick    = ($urandom_range(0, 7) == 0);
         hit_sec = ($urandom_range(0, 7) == 0);
         hit_min = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
